led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Multi-channel, run-time configurable signal generator driving board LEDs or downstream strobe logic. Each of CHANNELS outputs has its own period counter and high-time, and can be set to off, toggle, PWM or on. Settings change through a single-cycle configuration write port, and a global restart realigns all channels. It replaces per-LED fixed-delay dividers in top-level designs; reset defaults reproduce a plain toggle at DEFAULT_PERIOD.

## Interface
- CHANNELS, 3: number of independent output channels (1..16)
- CNT_W, 26: width of period/high-time registers and counters
- DEFAULT_PERIOD, 50000000: reset value of every channel's period (must fit CNT_W)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  configuration write strobe, one cycle per write
- cfg_ch  in  CH_W = max(1,$clog2(CHANNELS))  target channel
- cfg_sel  in  2  register select: 0 period, 1 high_time, 2 mode, 3 reserved (ignored)
- cfg_data  in  CNT_W  write data; mode uses bits [1:0]
- sync_restart  in  1  restart all channels' counters this cycle
- out  out  CHANNELS  generated signals, registered
- tick  out  CHANNELS  one-cycle pulse per channel on counter wrap, registered

## Operation
- Per channel: period P, high_time H, mode M, counter cnt, out bit, tick bit.
- Reset values: P = DEFAULT_PERIOD, H = DEFAULT_PERIOD/2, M = TOGGLE, cnt = 0, out = 0, tick = 0.
- Effective period Pe = 1 if P == 0, else P.
- Modes (M encoding):
  - 0 OFF: cnt held 0, out = 0, tick = 0.
  - 1 TOGGLE: cnt counts 0..Pe-1. On the wrap cycle (cnt == Pe-1): cnt becomes 0, out inverts, tick = 1.
  - 2 PWM: cnt counts as in TOGGLE. out = (new cnt < H), computed from the counter value loaded that same edge. tick = 1 on wrap. H = 0 gives out always 0; H >= Pe gives out always 1.
  - 3 ON: cnt held 0, out = 1, tick = 0.
- Config write (cfg_we = 1, cfg_ch < CHANNELS):
  - Selected register updated at the edge.
  - A write to period or mode also restarts that channel: cnt = 0, tick = 0. out = 0 for OFF/TOGGLE/PWM-with-H=0; out = 1 for ON or PWM with H > 0.
  - A write to high_time does not restart. The new H applies from the next counter step.
- cfg_ch >= CHANNELS or cfg_sel == 3: the write is ignored, no state changes.
- sync_restart applies a restart to all channels at the edge with the same out rule. Register values are unchanged.
- Simultaneous sync_restart and cfg_we:
  - The config value is stored.
  - The restart uses the newly written values (new P/M/H).
- Counter arithmetic is unsigned CNT_W. The comparison with Pe-1 prevents overflow, and cnt never exceeds Pe-1.
- Channels are fully independent apart from sync_restart.

## Timing
- Asynchronous assertion of rst_n forces all reset values immediately. Deassertion is synchronised by the integrator; the first active edge after release advances cnt to 1.
- Reset mid-operation aborts all counting and restores defaults, including configuration registers.
- TOGGLE: the first toggle occurs on the Pe-th edge after reset release or restart. The output period is 2*Pe cycles, with 50% duty.
- PWM: output period is Pe cycles. High for H cycles when 0 < H < Pe, starting one edge after a restart.
- tick is high for exactly the cycle in which cnt == 0 following a wrap. It is never asserted by restart or reset.
- Config write latency: one edge. Registers and restart effects are visible in the cycle after cfg_we.
- out and tick change only on clk edges (glitch-free). No combinational path from inputs to outputs.

## Test plan
- Defaults with DEFAULT_PERIOD overridden to 4, CHANNELS = 3: release reset -> all out rise together 4 edges after release and toggle every 4 cycles; tick pulses every 4 cycles on all channels.
- Ch1 PWM (write P = 5, H = 2, M = 2) -> out[1] repeats 1,1,0,0,0 from the edge after the mode write; tick[1] high once per 5 cycles. Then H = 0 -> constant 0, and H = 7 -> constant 1, with no restart.
- Ch0 OFF and ch2 ON -> out[0] = 0, out[2] = 1, tick[0] = tick[2] = 0 for 20 cycles. Ch1 is unaffected.
- Ch0 and ch1 in TOGGLE with P = 3 and P = 7, started at different times, then pulse sync_restart -> both cnt = 0 and out = 0. The first toggles occur 3 and 7 edges later.
- P = 0 in TOGGLE -> out toggles every cycle and tick stays 1. Also: a write with cfg_ch = 3 (CHANNELS = 3) and cfg_sel = 3 changes nothing.
- Same-cycle period write (ch0, P = 2) with sync_restart -> ch0 toggles 2 edges later. Then assert rst_n = 0 mid-count -> out and tick = 0 immediately, and configuration is back to defaults.

Source files
------------

// File: rtl/led_pattern_gen.sv
// Multi-channel configurable pattern generator (off / toggle / PWM / on).
// Each channel runs independently; channels share only the config write bus and sync_restart.

module led_pattern_chan #(
  parameter int CNT_W          = 26,
  parameter int DEFAULT_PERIOD = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [1:0]       sel_i,
  input  logic [CNT_W-1:0] data_i,
  input  logic             restart_i,
  output logic             out_o,
  output logic             tick_o
);
  typedef enum logic [1:0] {
    M_OFF    = 2'd0,
    M_TOGGLE = 2'd1,
    M_PWM    = 2'd2,
    M_ON     = 2'd3
  } mode_e;

  localparam logic [1:0]       SEL_PER  = 2'd0;
  localparam logic [1:0]       SEL_HIGH = 2'd1;
  localparam logic [1:0]       SEL_MODE = 2'd2;
  localparam logic [CNT_W-1:0] RST_PER  = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_PERIOD / 2);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last, step;
  mode_e            mode_q, mode_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             restart, wrap;

  // Post-write register view; a restart in the same cycle must see these values.
  always_comb begin
    per_d  = per_q;
    high_d = high_q;
    mode_d = mode_q;
    if (wr_i) begin
      case (sel_i)
        SEL_PER:  per_d  = data_i;
        SEL_HIGH: high_d = data_i;
        SEL_MODE: mode_d = mode_e'(data_i[1:0]);
        default:  ;
      endcase
    end
  end

  // Comparing against Pe-1 (P==0 treated as 1) keeps cnt+1 from ever overflowing.
  assign restart = restart_i || (wr_i && (sel_i == SEL_PER || sel_i == SEL_MODE));
  assign last    = (per_q == '0) ? '0 : per_q - ONE;
  assign wrap    = (cnt_q == last);
  assign step    = wrap ? '0 : cnt_q + ONE;

  always_comb begin
    cnt_d  = '0;
    out_d  = 1'b0;
    tick_d = 1'b0;
    if (restart) begin
      out_d = (mode_d == M_ON) || (mode_d == M_PWM && high_d != '0);
    end else begin
      case (mode_q)
        M_TOGGLE: begin
          cnt_d  = step;
          tick_d = wrap;
          out_d  = out_q ^ wrap;
        end
        M_PWM: begin
          cnt_d  = step;
          tick_d = wrap;
          out_d  = (step < high_q);
        end
        M_ON:    out_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q  <= RST_PER;
      high_q <= RST_HIGH;
      mode_q <= M_TOGGLE;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      per_q  <= per_d;
      high_q <= high_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign out_o  = out_q;
  assign tick_o = tick_q;
endmodule

module led_pattern_gen #(
  parameter  int CHANNELS       = 3,
  parameter  int CNT_W          = 26,
  parameter  int DEFAULT_PERIOD = 50000000,
  localparam int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_sel,
  input  logic [CNT_W-1:0]    cfg_data,
  input  logic                sync_restart,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] tick
);
  // Out-of-range cfg_ch matches no instance, so such writes fall away naturally.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic hit;
    assign hit = cfg_we && (cfg_ch == CH_W'(i));

    led_pattern_chan #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_i      (hit),
      .sel_i     (cfg_sel),
      .data_i    (cfg_data),
      .restart_i (sync_restart),
      .out_o     (out[i]),
      .tick_o    (tick[i])
    );
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus random config traffic,
// checked against a phase-count model (edges since restart, div/mod by Pe).

module tb_led_pattern_gen;
  localparam int CH  = 3;
  localparam int W   = 26;
  localparam int DEF = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [1:0]    cfg_sel = '0;
  logic [W-1:0]  cfg_data = '0;
  logic          sync_restart = 1'b0;
  logic [CH-1:0] out, tick;

  always #5 clk = ~clk;

  led_pattern_gen #(.CHANNELS(CH), .CNT_W(W), .DEFAULT_PERIOD(DEF)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
    .sync_restart (sync_restart),
    .out          (out),
    .tick         (tick)
  );

  int n_cmp = 0;
  int n_bad = 0;

  longint        mP[CH], mH[CH], mK[CH];
  int            mM[CH];
  logic [CH-1:0] eo, et;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mP[c] = DEF; mH[c] = DEF / 2; mM[c] = 1; mK[c] = 0;
    end
    eo = '0; et = '0;
  endtask

  // mK = edges since last restart; outputs follow from Pe and H by arithmetic.
  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      longint h_old, pe;
      bit hit, rs;
      h_old = mH[c];
      hit = cfg_we && (int'(cfg_ch) == c) && (cfg_sel != 2'd3);
      if (hit) begin
        case (cfg_sel)
          2'd0: mP[c] = longint'(cfg_data);
          2'd1: mH[c] = longint'(cfg_data);
          2'd2: mM[c] = int'(cfg_data[1:0]);
          default: ;
        endcase
      end
      rs = sync_restart || (hit && (cfg_sel == 2'd0 || cfg_sel == 2'd2));
      if (rs || mM[c] == 0 || mM[c] == 3) mK[c] = 0;
      else mK[c] = mK[c] + 1;
      pe = (mP[c] == 0) ? 1 : mP[c];
      case (mM[c])
        0: begin eo[c] = 1'b0; et[c] = 1'b0; end
        3: begin eo[c] = 1'b1; et[c] = 1'b0; end
        1: begin
          eo[c] = ((mK[c] / pe) % 2) == 1;
          et[c] = !rs && (mK[c] % pe == 0);
        end
        default: begin
          eo[c] = rs ? (mH[c] > 0) : ((mK[c] % pe) < h_old);
          et[c] = !rs && (mK[c] % pe == 0);
        end
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    cfg_we = 1'b0;
    sync_restart = 1'b0;
  endtask

  task automatic wr(input int ch, input int sel, input longint d);
    cfg_we = 1'b1;
    cfg_ch = ch[1:0];
    cfg_sel = sel[1:0];
    cfg_data = d[W-1:0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out !== 3'b000 || tick !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_state out=%b tick=%b want 000/000", out, tick);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_defaults();
    for (int i = 1; i <= 12; i++) begin
      cycle();
      n_cmp++;
      if (out !== eo || tick !== et) begin
        n_bad++;
        $display("FAIL defaults i=%0d out=%b/%b tick=%b/%b", i, out, eo, tick, et);
      end
      if (i == 4) begin
        n_cmp++;
        if (out !== 3'b111 || tick !== 3'b111) begin
          n_bad++;
          $display("FAIL defaults_first_toggle out=%b tick=%b want 111/111", out, tick);
        end
      end
    end
  endtask

  task automatic test_pwm();
    int nt;
    wr(1, 0, 5); cycle();
    wr(1, 1, 2); cycle();
    wr(1, 2, 2); cycle();
    n_cmp++;
    if (out !== eo || tick !== et || out[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL pwm_start out=%b/%b tick=%b/%b", out, eo, tick, et);
    end
    nt = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      nt += int'(tick[1]);
      n_cmp++;
      if (out !== eo || tick !== et) begin
        n_bad++;
        $display("FAIL pwm i=%0d out=%b/%b tick=%b/%b", i, out, eo, tick, et);
      end
    end
    n_cmp++;
    if (nt != 2) begin
      n_bad++;
      $display("FAIL pwm_tick_count got=%0d want=2", nt);
    end
    wr(1, 1, 0); cycle();
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_cmp++;
      if (out !== eo || tick !== et || out[1] !== 1'b0) begin
        n_bad++;
        $display("FAIL pwm_h0 i=%0d out=%b/%b tick=%b/%b", i, out, eo, tick, et);
      end
    end
    wr(1, 1, 7); cycle();
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_cmp++;
      if (out !== eo || tick !== et || out[1] !== 1'b1) begin
        n_bad++;
        $display("FAIL pwm_hbig i=%0d out=%b/%b tick=%b/%b", i, out, eo, tick, et);
      end
    end
  endtask

  task automatic test_off_on();
    wr(0, 2, 0); cycle();
    wr(2, 2, 3); cycle();
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_cmp++;
      if (out !== eo || tick !== et || out[0] !== 1'b0 || out[2] !== 1'b1 ||
          tick[0] !== 1'b0 || tick[2] !== 1'b0) begin
        n_bad++;
        $display("FAIL off_on i=%0d out=%b/%b tick=%b/%b", i, out, eo, tick, et);
      end
    end
  endtask

  task automatic test_sync_restart();
    wr(0, 0, 3); cycle();
    wr(0, 2, 1); cycle();
    repeat (4) cycle();
    wr(1, 0, 7); cycle();
    wr(1, 2, 1); cycle();
    repeat (5) cycle();
    sync_restart = 1'b1;
    cycle();
    n_cmp++;
    if (out !== eo || tick !== et || out[1:0] !== 2'b00 || tick[1:0] !== 2'b00) begin
      n_bad++;
      $display("FAIL sync_restart out=%b/%b tick=%b/%b", out, eo, tick, et);
    end
    for (int i = 1; i <= 8; i++) begin
      cycle();
      n_cmp++;
      if (out !== eo || tick !== et ||
          (i == 2 && out[0] !== 1'b0) || (i == 3 && out[0] !== 1'b1) ||
          (i == 6 && out[1] !== 1'b0) || (i == 7 && out[1] !== 1'b1)) begin
        n_bad++;
        $display("FAIL sync_after i=%0d out=%b/%b tick=%b/%b", i, out, eo, tick, et);
      end
    end
  endtask

  task automatic test_p_zero();
    wr(2, 0, 0); cycle();
    wr(2, 2, 1); cycle();
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_cmp++;
      if (out !== eo || tick !== et || tick[2] !== 1'b1) begin
        n_bad++;
        $display("FAIL p_zero i=%0d out=%b/%b tick=%b/%b", i, out, eo, tick, et);
      end
    end
    wr(3, 0, 9); cycle();
    wr(0, 3, 1); cycle();
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_cmp++;
      if (out !== eo || tick !== et) begin
        n_bad++;
        $display("FAIL ignored_wr i=%0d out=%b/%b tick=%b/%b", i, out, eo, tick, et);
      end
    end
  endtask

  task automatic test_same_cycle();
    wr(0, 0, 2);
    sync_restart = 1'b1;
    cycle();
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) cycle();
      n_cmp++;
      if (out !== eo || tick !== et || (i == 0 && out[0] !== 1'b0) ||
          (i == 1 && out[0] !== 1'b0) || (i == 2 && out[0] !== 1'b1)) begin
        n_bad++;
        $display("FAIL same_cycle i=%0d out=%b/%b tick=%b/%b", i, out, eo, tick, et);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) == 0) wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), longint'(r[W-1:0]));
        else wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), longint'($urandom_range(0, 12)));
      end
      if ($urandom_range(0, 15) == 0) sync_restart = 1'b1;
      cycle();
      n_cmp++;
      if (out !== eo || tick !== et) begin
        n_bad++;
        $display("FAIL random i=%0d out=%b/%b tick=%b/%b", i, out, eo, tick, et);
      end
    end
  endtask

  task automatic test_reset_mid();
    wr(0, 2, 3); cycle();
    repeat (3) cycle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (out !== 3'b000 || tick !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_mid out=%b tick=%b want 000/000", out, tick);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      n_cmp++;
      if (out !== eo || tick !== et || (i == 4 && out !== 3'b111)) begin
        n_bad++;
        $display("FAIL reset_defaults i=%0d out=%b/%b tick=%b/%b", i, out, eo, tick, et);
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_pwm();
    test_off_on();
    test_sync_restart();
    test_p_zero();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
